// File: rtl/prospect_car_queue_if.sv
// Bundle between the Prospect Ave loop detector / light source and the car queue.
// master drives the sensor and light code; slave (the queue) returns status and pulses.
interface prospect_car_queue_if #(
  parameter int unsigned CNT_W = 4
);
  logic             sensor_raw;
  logic [2:0]       light_pros;
  logic             car_present;
  logic [CNT_W-1:0] car_count;
  logic             arrive_pulse;
  logic             depart_pulse;
  logic             overflow;
  logic             light_err;

  modport master (
    output sensor_raw, light_pros,
    input  car_present, car_count, arrive_pulse, depart_pulse, overflow, light_err
  );

  modport slave (
    input  sensor_raw, light_pros,
    output car_present, car_count, arrive_pulse, depart_pulse, overflow, light_err
  );
endinterface

// File: rtl/prospect_car_queue.sv
// Prospect Ave car queue: debounces the loop detector, counts arrivals and paced
// departures on green, and reports queue state and illegal light codes.
module prospect_car_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DEPART_CYCLES   = 8,
  parameter int unsigned MAX_CARS        = 15,
  parameter int unsigned CNT_W           = 4
) (
  input logic                 clk,
  input logic                 rst,
  prospect_car_queue_if.slave bus
);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

  localparam logic [2:0] LightRed = 3'b001;
  localparam logic [2:0] LightYlw = 3'b010;
  localparam logic [2:0] LightGrn = 3'b100;

  typedef enum logic [1:0] {StIdle, StRiseChk, StOccupied, StFallChk} deb_state_e;

  deb_state_e       state_q;
  logic [DW-1:0]    dcnt_q;
  logic [PW-1:0]    pcnt_q;
  logic             s_meta_q, s_sync_q;
  logic [CNT_W-1:0] count_q;
  logic             arrive_q, depart_q, overflow_q, light_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      dcnt_q      <= '0;
      pcnt_q      <= '0;
      s_meta_q    <= 1'b0;
      s_sync_q    <= 1'b0;
      count_q     <= '0;
      arrive_q    <= 1'b0;
      depart_q    <= 1'b0;
      overflow_q  <= 1'b0;
      light_err_q <= 1'b0;
    end else begin
      s_meta_q <= bus.sensor_raw;
      s_sync_q <= s_meta_q;

      // The edge that would make dcnt reach DEBOUNCE_CYCLES commits the new level.
      arrive_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s_sync_q) begin
            state_q <= StRiseChk;
            dcnt_q  <= DW'(1);
          end
        end
        StRiseChk: begin
          if (!s_sync_q) begin
            state_q <= StIdle;
          end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_q  <= StOccupied;
            arrive_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        StOccupied: begin
          if (!s_sync_q) begin
            state_q <= StFallChk;
            dcnt_q  <= DW'(1);
          end
        end
        StFallChk: begin
          if (s_sync_q) begin
            state_q <= StOccupied;
          end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_q <= StIdle;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
      endcase

      depart_q <= 1'b0;
      if (bus.light_pros == LightGrn && count_q != '0) begin
        if (pcnt_q == PW'(DEPART_CYCLES - 1)) begin
          depart_q <= 1'b1;
          pcnt_q   <= '0;
        end else begin
          pcnt_q <= pcnt_q + PW'(1);
        end
      end else begin
        pcnt_q <= '0;
      end

      // Count follows the pulses one cycle later; simultaneous events cancel.
      if (arrive_q && !depart_q) begin
        if (count_q == CNT_W'(MAX_CARS)) begin
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end else if (depart_q && !arrive_q) begin
        count_q <= count_q - CNT_W'(1);
      end

      light_err_q <= !(bus.light_pros inside {LightRed, LightYlw, LightGrn});
    end
  end

  assign bus.car_present  = (count_q != '0);
  assign bus.car_count    = count_q;
  assign bus.arrive_pulse = arrive_q;
  assign bus.depart_pulse = depart_q;
  assign bus.overflow     = overflow_q;
  assign bus.light_err    = light_err_q;
endmodule
